// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and fill-counter width helper for the sequence detector.
package seq_det_pkg;
    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam logic [3:0] PAT_INIT_DEF = 4'b1011;
    function automatic int fill_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial input, pattern load and match result signals of the detector.
interface seq_detect_param_if import seq_det_pkg::*; #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             seq;
    logic             in_valid;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] mask;
    logic             out;
    logic [CNT_W-1:0] count;
    logic             sat;
    modport master (output seq, in_valid, load, pattern, mask, input out, count, sat);
    modport slave  (input seq, in_valid, load, pattern, mask, output out, count, sat);
endinterface

// File: rtl/seq_det_shift.sv
// seq_det_shift: bit history plus saturating fill count; exposes the post-shift view for matching.
module seq_det_shift import seq_det_pkg::*; #(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             shift_i,
    input  logic             restart_i,
    input  logic             zap_i,
    input  logic             seq_i,
    output logic [PAT_W-1:0] hist_o,
    output logic             full_o
);
    localparam int FW = fill_w(PAT_W);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_inc, fill_d;
    always_comb begin
        hist_d   = shift_i ? {hist_q[PAT_W-2:0], seq_i} : hist_q;
        fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        fill_d   = (restart_i || zap_i) ? '0 : shift_i ? fill_inc : fill_q;
    end
    assign hist_o = hist_d;
    assign full_o = (fill_inc == FULL);
    always_ff @(posedge clk) begin
        if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: masked serial pattern detector with registered match pulse and saturating count.
module seq_detect_param import seq_det_pkg::*; #(
    parameter int               PAT_W    = PAT_W_DEF,
    parameter int               CNT_W    = CNT_W_DEF,
    parameter int               OVERLAP  = 1,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_INIT_DEF)
) (
    input  logic              clk,
    input  logic              clear,
    seq_detect_param_if.slave bus
);
    logic [PAT_W-1:0] pat_q, mask_q, hist_d;
    logic [CNT_W-1:0] count_q;
    logic             out_q, full, en, match;
    assign en    = bus.in_valid & ~bus.load;
    assign match = en & full & ~|((hist_d ^ pat_q) & mask_q);
    seq_det_shift #(.PAT_W(PAT_W)) u_shift (
        .clk       (clk),
        .clear     (clear),
        .shift_i   (en),
        .restart_i (bus.load),
        .zap_i     (match && (OVERLAP == 0)),
        .seq_i     (bus.seq),
        .hist_o    (hist_d),
        .full_o    (full)
    );
    always_ff @(posedge clk) begin
        if (clear) begin
            pat_q   <= PAT_INIT;
            mask_q  <= '1;
            out_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (bus.load) begin
                pat_q  <= bus.pattern;
                mask_q <= bus.mask;
            end
            out_q   <= match;
            count_q <= bus.load ? '0 : (match && !(&count_q)) ? count_q + 1'b1 : count_q;
        end
    end
    assign bus.out   = out_q;
    assign bus.count = count_q;
    assign bus.sat   = &count_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: three detector variants on one stimulus, checked against a bit-list model.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic clear, seq, vld, ld;
    logic [3:0] pat, msk;
    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if0 ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if1 ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) if2 ();
    assign {if0.seq, if0.in_valid, if0.load, if0.pattern, if0.mask} = {seq, vld, ld, pat, msk};
    assign {if1.seq, if1.in_valid, if1.load, if1.pattern, if1.mask} = {seq, vld, ld, pat, msk};
    assign {if2.seq, if2.in_valid, if2.load, if2.pattern, if2.mask} = {seq, vld, ld, pat, msk};

    seq_detect_param #(.OVERLAP(1)) dut0 (.clk(clk), .clear(clear), .bus(if0));
    seq_detect_param #(.OVERLAP(0)) dut1 (.clk(clk), .clear(clear), .bus(if1));
    seq_detect_param #(.OVERLAP(1), .CNT_W(2)) dut2 (.clk(clk), .clear(clear), .bus(if2));

    int errs = 0, checks = 0;
    bit started = 0;
    localparam int OVL[3]  = '{1, 0, 1};
    localparam int CMAX[3] = '{255, 255, 3};
    int m_len[3], m_cnt[3];
    logic [3:0] m_bits[3], m_pat[3], m_msk[3];
    logic m_out[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: count bits received since the last restart; match when the newest four agree on every masked position.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (clear) begin
                started = 1;
                m_len[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
                m_pat[k] = 4'b1011; m_msk[k] = 4'b1111;
            end else if (ld) begin
                m_len[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
                m_pat[k] = pat; m_msk[k] = msk;
            end else if (vld) begin
                bit ok;
                m_bits[k] = {m_bits[k][2:0], seq};
                m_len[k]++;
                ok = (m_len[k] >= 4);
                for (int i = 0; i < 4; i++)
                    if (m_msk[k][i] && m_bits[k][i] != m_pat[k][i]) ok = 0;
                m_out[k] = ok;
                if (ok && m_cnt[k] < CMAX[k]) m_cnt[k]++;
                if (ok && OVL[k] == 0) m_len[k] = 0;
            end else begin
                m_out[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out0", if0.out, m_out[0]);
            chk("out1", if1.out, m_out[1]);
            chk("out2", if2.out, m_out[2]);
            chk("count0", if0.count, m_cnt[0]);
            chk("count1", if1.count, m_cnt[1]);
            chk("count2", if2.count, m_cnt[2]);
            chk("sat0", if0.sat, m_cnt[0] == CMAX[0]);
            chk("sat1", if1.sat, m_cnt[1] == CMAX[1]);
            chk("sat2", if2.sat, m_cnt[2] == CMAX[2]);
        end
    end

    task automatic step(input logic c, l, v, s, input logic [3:0] p, m);
        @(negedge clk);
        clear = c; ld = l; vld = v; seq = s; pat = p; msk = m;
    endtask

    task automatic bitx(input logic s, v, e0, e1, e2);
        step(1'b0, 1'b0, v, s, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        chk("lit_out0", if0.out, e0);
        chk("lit_out1", if1.out, e1);
        chk("lit_out2", if2.out, e2);
    endtask

    initial begin
        clear = 1; ld = 0; vld = 0; seq = 0; pat = 0; msk = 0;
        step(1, 0, 0, 0, 4'h0, 4'h0);
        @(posedge clk); #1;
        chk("rst_out", if0.out, 0);
        chk("rst_count", if0.count, 0);
        chk("rst_sat", if2.sat, 0);
        // 1,0,1,1,0,1,1 against the reset pattern 1011
        bitx(1, 1, 0, 0, 0); bitx(0, 1, 0, 0, 0); bitx(1, 1, 0, 0, 0); bitx(1, 1, 1, 1, 1);
        bitx(0, 1, 0, 0, 0); bitx(1, 1, 0, 0, 0); bitx(1, 1, 1, 0, 1);
        chk("ovl_count", if0.count, 2);
        chk("novl_count", if1.count, 1);
        chk("model_count", m_cnt[0], 2);
        // load with in_valid: the bit must not count towards fill
        step(0, 1, 1, 1, 4'b1001, 4'b1001);
        @(posedge clk); #1;
        chk("load_count", if0.count, 0);
        bitx(1, 1, 0, 0, 0); bitx(1, 1, 0, 0, 0); bitx(1, 1, 0, 0, 0); bitx(1, 1, 1, 1, 1);
        chk("mask_count", if1.count, 1);
        // all-zero mask: every bit matches once full, driving the 2-bit counter into saturation
        step(0, 1, 0, 0, 4'b0000, 4'b0000);
        bitx(1, 1, 0, 0, 0); bitx(0, 1, 0, 0, 0); bitx(1, 1, 0, 0, 0); bitx(1, 1, 1, 1, 1);
        bitx(0, 1, 1, 0, 1); bitx(0, 1, 1, 0, 1); bitx(1, 1, 1, 0, 1); bitx(1, 1, 1, 1, 1);
        chk("sat_count", if2.count, 3);
        chk("sat_flag", if2.sat, 1);
        chk("novl_zero_mask", if1.count, 2);
        bitx(0, 1, 1, 0, 1);
        chk("sat_hold", if2.count, 3);
        chk("wide_count", if0.count, 6);
        // gaps between valid bits
        step(0, 1, 0, 0, 4'b1011, 4'b1111);
        bitx(1, 1, 0, 0, 0); bitx(1, 0, 0, 0, 0); bitx(0, 1, 0, 0, 0); bitx(0, 0, 0, 0, 0);
        bitx(1, 0, 0, 0, 0); bitx(1, 1, 0, 0, 0); bitx(0, 0, 0, 0, 0); bitx(1, 1, 1, 1, 1);
        bitx(1, 0, 0, 0, 0);
        chk("gap_count", if0.count, 1);
        // clear mid-pattern must discard progress: 1,0,1 + clear + 1 would otherwise match
        bitx(1, 1, 0, 0, 0); bitx(0, 1, 0, 0, 0); bitx(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 4'h0, 4'h0);
        @(posedge clk); #1;
        chk("clr_count", if0.count, 0);
        bitx(1, 1, 0, 0, 0);
        chk("clr_nomatch", if0.count, 0);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning overlapping (1) or non-overlapping (0) detection.
REQ-004 The block SHALL have parameter PAT_INIT, default 4'b1011, meaning the pattern loaded by reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port clear, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port seq, input, 1 bit: serial data bit.
REQ-008 The block SHALL have port in_valid, input, 1 bit: seq is sampled on this edge.
REQ-009 The block SHALL have port load, input, 1 bit: capture pattern/mask and restart detection.
REQ-010 The block SHALL have port pattern, input, PAT_W bits: new pattern, MSB = first bit received.
REQ-011 The block SHALL have port mask, input, PAT_W bits: 1 = compare bit, 0 = don't-care.
REQ-012 The block SHALL have port out, output, 1 bit: registered one-cycle match pulse.
REQ-013 The block SHALL have port count, output, CNT_W bits: saturating match count.
REQ-014 The block SHALL have port sat, output, 1 bit: high while count is all-ones.

Function
REQ-015 The block SHALL hold a PAT_W-bit history register; on each edge with in_valid=1 and load=0, history shifts left and seq enters at LSB.
REQ-016 The block SHALL hold a fill counter of width clog2(PAT_W+1); it increments on each sampled bit and saturates at PAT_W.
REQ-017 A match SHALL be declared on an edge that samples a bit when the post-shift fill equals PAT_W and ((history_next XOR pattern_reg) AND mask_reg) == 0.
REQ-018 out SHALL be 1 in the cycle immediately after the edge sampling the final pattern bit (latency 1), and 0 otherwise; it SHALL never be high for two consecutive cycles unless matches occur on consecutive sampled bits.
REQ-019 With OVERLAP=1, fill SHALL be unaffected by a match; with OVERLAP=0, fill SHALL be set to 0 on the matching edge so that no bit is reused.
REQ-020 Edges with in_valid=0 SHALL change no state other than forcing out to 0.
REQ-021 On each match, count SHALL increment by 1, holding at 2^CNT_W-1; sat SHALL equal (count == all-ones).
REQ-022 On an edge with load=1, pattern_reg<=pattern, mask_reg<=mask, fill<=0, out<=0, and count<=0; seq is discarded even if in_valid=1 (load wins).
REQ-023 An all-zero mask_reg SHALL match on every sampled bit once fill==PAT_W.

Reset
REQ-024 On an edge with clear=1 (priority over load and in_valid): history=0, fill=0, out=0, count=0, sat=0, pattern_reg=PAT_INIT, mask_reg=all-ones.
REQ-025 A clear asserted mid-pattern SHALL discard all partial progress; the first match after reset SHALL require PAT_W fresh sampled bits.

Structure
REQ-026 Shared package seq_det_pkg SHALL hold the default PAT_W, CNT_W, PAT_INIT constants and the fill-width function.
REQ-027 History register plus fill counter SHALL form one sub-module, seq_det_shift; the compare, counter and out register SHALL remain in seq_detect_param.

Verification
REQ-028 The bench SHALL cover overlap: defaults, clear, then bits 1,0,1,1,0,1,1 valid every cycle -> out pulses after the 4th and 7th bits, count=2.
REQ-029 The bench SHALL cover non-overlap: OVERLAP=0, same stream -> single pulse after the 4th bit, count=1.
REQ-030 The bench SHALL cover mask and load: load pattern=4'b1001, mask=4'b1001, then stream 1,1,1,1 -> pulse after the 4th bit; load and in_valid on the same edge -> bit ignored, fill=0.
REQ-031 The bench SHALL cover gaps and clear: stream 1,0,1 with in_valid=0 gaps then 1 -> pulse one cycle after the final valid bit; clear after 3 bits then 1 -> no pulse.
REQ-032 The bench SHALL cover saturation: CNT_W=2, five matches -> count=3, sat=1, count holds at 3.
